// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: redirect, instruction-memory request/response, decode delivery.
// Latency: none (wires only).
// Backpressure: imem_req_ready and inst_ready stall the fetch master.
interface inst_fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;

  // The fetch stage drives requests and delivered instructions.
  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_ready,
    output imem_req_valid, imem_addr,
    output inst_valid, inst, inst_pc, inst_pc4
  );

  // Memory, decode and redirect source as seen from the other side.
  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_ready,
    input  imem_req_valid, imem_addr,
    input  inst_valid, inst, inst_pc, inst_pc4
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues in-order imem reads into a DEPTH-entry ring, delivers {inst, pc}.
// Latency: request at t, response at t+k -> inst_valid at t+k+1 (t+k with IFETCH_BYPASS_EN defined).
// Backpressure: issue stops when DEPTH entries are allocated; inst_ready low holds the head entry.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  inst_fetch_if.master  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  // Discard has to cover stale responses left over from an earlier redirect as
  // well as the entries abandoned by the current one.
  localparam int DW = $clog2(2 * DEPTH + 1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];
  logic [31:0]      word_q [DEPTH];
  logic [31:0]      word_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    fill_q, fill_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    pend_q, pend_d;      // allocated entries still waiting for data
  logic [DW-1:0]    discard_q, discard_d;

  logic req_fire;
  logic rsp_drop;
  logic rsp_fill;
  logic head_filled;
  logic byp_hit;
  logic deliver;

  // Handshake decode and delivery outputs.
  always_comb begin
    bus.imem_req_valid = !reset && !bus.redirect_valid && (count_q < CW'(DEPTH));
    bus.imem_addr      = fetch_pc_q;
    req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    rsp_drop           = bus.imem_rsp_valid && (discard_q != '0);
    // A response with nothing waiting for it is ignored.
    rsp_fill           = bus.imem_rsp_valid && (discard_q == '0) && (pend_q != '0);
    head_filled        = filled_q[head_q];
`ifdef IFETCH_BYPASS_EN
    byp_hit            = rsp_fill && (count_q != '0) && !head_filled && (fill_q == head_q);
`else
    byp_hit            = 1'b0;
`endif
    bus.inst_valid     = (count_q != '0) && (head_filled || byp_hit);
    bus.inst           = byp_hit ? bus.imem_rsp_data : word_q[head_q];
    bus.inst_pc        = pc_q[head_q];
    bus.inst_pc4       = pc_q[head_q] + 32'd4;
    deliver            = bus.inst_valid && bus.inst_ready;
  end

  // Next-state: allocate, fill and retire; a redirect then flushes on top of that.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    word_d     = word_q;
    filled_d   = filled_q;
    head_d     = head_q;
    fill_d     = fill_q;
    tail_d     = tail_q;
    count_d    = count_q;
    pend_d     = pend_q;
    discard_d  = discard_q;

    if (req_fire) begin
      pc_d[tail_q]     = fetch_pc_q;
      filled_d[tail_q] = 1'b0;
      tail_d           = tail_q + PW'(1);
      fetch_pc_d       = fetch_pc_q + 32'd4;
    end
    if (rsp_drop) begin
      discard_d = discard_q - DW'(1);
    end
    if (rsp_fill) begin
      word_d[fill_q]   = bus.imem_rsp_data;
      filled_d[fill_q] = 1'b1;
      fill_d           = fill_q + PW'(1);
    end
    if (deliver) begin
      head_d = head_q + PW'(1);
    end
    count_d = count_q + CW'(req_fire) - CW'(deliver);
    pend_d  = pend_q + CW'(req_fire) - CW'(rsp_fill);

    // Everything allocated is abandoned; responses still owed for unfilled
    // entries must be swallowed when they arrive.
    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      filled_d   = '0;
      head_d     = '0;
      fill_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      pend_d     = '0;
      discard_d  = discard_q - DW'(rsp_drop) + DW'(pend_q) - DW'(rsp_fill);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        word_q[i] <= '0;
      end
      filled_q  <= '0;
      head_q    <= '0;
      fill_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pend_q    <= '0;
      discard_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= pc_d[i];
        word_q[i] <= word_d[i];
      end
      filled_q  <= filled_d;
      head_q    <= head_d;
      fill_q    <= fill_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed cycle-by-cycle bench for inst_fetch (RESET_PC = 0x40, DEPTH = 2).
// Latency: inputs applied just after each falling edge, outputs sampled 1 time unit later.
// Backpressure: imem_req_ready / inst_ready driven explicitly per cycle.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  inst_fetch_if bus ();

  inst_fetch #(
    .RESET_PC (32'h0000_0040),
    .DEPTH    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef IFETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  // Instruction word the memory returns for a given address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; returns just after the inputs settle.
  task automatic cyc(input logic rr, input logic rv, input logic [31:0] rd,
                     input logic ir, input logic xv, input logic [31:0] xpc);
    @(negedge clk);
    bus.imem_req_ready = rr;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    bus.inst_ready     = ir;
    bus.redirect_valid = xv;
    bus.redirect_pc    = xpc;
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk({tag, "_iv"},  32'(bus.inst_valid),     32'd0);
    chk({tag, "_req"}, 32'(bus.imem_req_valid), 32'd0);
    chk({tag, "_pc"},  bus.inst_pc,             32'd0);
    chk({tag, "_pc4"}, bus.inst_pc4,            32'd4);
    chk({tag, "_ins"}, bus.inst,                32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset values.
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_iv",  32'(bus.inst_valid),     32'd0);
    chk("rst_req", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_ins", bus.inst,                32'd0);
    chk("rst_pc",  bus.inst_pc,             32'd0);
    chk("rst_pc4", bus.inst_pc4,            32'd4);
    cyc(0, 0, 0, 0, 0, 0);
    reset = 1'b0;

`ifndef IFETCH_BYPASS_EN
    // Streaming with 1-cycle memory and decode always ready.
    cyc(1, 0, 0, 1, 0, 0);
    chk("a0_req",  32'(bus.imem_req_valid), 32'd1);
    chk("a0_addr", bus.imem_addr, 32'h40);
    chk("a0_iv",   32'(bus.inst_valid), 32'd0);
    cyc(1, 1, mem_word(32'h40), 1, 0, 0);
    chk("a1_addr", bus.imem_addr, 32'h44);
    chk("a1_iv",   32'(bus.inst_valid), 32'd0);
    cyc(1, 1, mem_word(32'h44), 1, 0, 0);
    chk("a2_req",  32'(bus.imem_req_valid), 32'd0);
    chk("a2_iv",   32'(bus.inst_valid), 32'd1);
    chk("a2_pc",   bus.inst_pc,  32'h40);
    chk("a2_ins",  bus.inst,     mem_word(32'h40));
    chk("a2_pc4",  bus.inst_pc4, 32'h44);
    cyc(1, 0, 0, 1, 0, 0);
    chk("a3_addr", bus.imem_addr, 32'h48);
    chk("a3_pc",   bus.inst_pc,  32'h44);
    chk("a3_ins",  bus.inst,     mem_word(32'h44));
    cyc(1, 1, mem_word(32'h48), 1, 0, 0);
    chk("a4_addr", bus.imem_addr, 32'h4C);
    chk("a4_iv",   32'(bus.inst_valid), 32'd0);
    cyc(1, 1, mem_word(32'h4C), 1, 0, 0);
    chk("a5_iv",   32'(bus.inst_valid), 32'd1);
    chk("a5_pc",   bus.inst_pc, 32'h48);
    cyc(0, 0, 0, 0, 0, 0);
    chk("a6_pc",   bus.inst_pc, 32'h4C);
    pulse_reset("a_rst");
`endif

    // Backpressure: decode stalls for five cycles.
    cyc(1, 0, 0, 0, 0, 0);
    chk("b0_addr", bus.imem_addr, 32'h40);
    cyc(1, 1, mem_word(32'h40), 0, 0, 0);
    cyc(1, 1, mem_word(32'h44), 0, 0, 0);
    chk("b2_req",  32'(bus.imem_req_valid), 32'd0);
    chk("b2_pc",   bus.inst_pc, 32'h40);
    cyc(1, 0, 0, 0, 0, 0);
    chk("b3_req",  32'(bus.imem_req_valid), 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("b4_req",  32'(bus.imem_req_valid), 32'd0);
    chk("b4_iv",   32'(bus.inst_valid), 32'd1);
    cyc(1, 0, 0, 1, 0, 0);
    chk("b5_pc",   bus.inst_pc, 32'h40);
    chk("b5_ins",  bus.inst,    mem_word(32'h40));
    cyc(1, 0, 0, 1, 0, 0);
    chk("b6_pc",   bus.inst_pc, 32'h44);
    chk("b6_ins",  bus.inst,    mem_word(32'h44));
    chk("b6_addr", bus.imem_addr, 32'h48);
    cyc(0, 0, 0, 1, 0, 0);
    chk("b7_iv",   32'(bus.inst_valid), 32'd0);
    chk("b7_addr", bus.imem_addr, 32'h4C);

    // Redirect to an unaligned target with two requests outstanding.
    cyc(1, 0, 0, 1, 0, 0);
    chk("c8_addr", bus.imem_addr, 32'h4C);
    cyc(1, 0, 0, 1, 1, 32'h0000_1002);
    chk("c9_req",  32'(bus.imem_req_valid), 32'd0);
    cyc(1, 1, mem_word(32'h48), 1, 0, 0);
    chk("c10_req",  32'(bus.imem_req_valid), 32'd1);
    chk("c10_addr", bus.imem_addr, 32'h1000);
    chk("c10_iv",   32'(bus.inst_valid), 32'd0);
    cyc(0, 1, mem_word(32'h4C), 1, 0, 0);
    chk("c11_addr", bus.imem_addr, 32'h1004);
    chk("c11_iv",   32'(bus.inst_valid), 32'd0);
    cyc(0, 1, mem_word(32'h1000), 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("c13_iv",  32'(bus.inst_valid), 32'd1);
    chk("c13_pc",  bus.inst_pc,  32'h1000);
    chk("c13_ins", bus.inst,     mem_word(32'h1000));
    chk("c13_pc4", bus.inst_pc4, 32'h1004);
    cyc(0, 0, 0, 0, 0, 0);
    chk("c14_iv",  32'(bus.inst_valid), 32'd0);

    // Redirect coinciding with a delivery and a response.
    cyc(1, 0, 0, 0, 0, 0);
    chk("d0_addr", bus.imem_addr, 32'h1004);
    cyc(1, 1, mem_word(32'h1004), 0, 0, 0);
    chk("d1_addr", bus.imem_addr, 32'h1008);
    cyc(1, 1, mem_word(32'h1008), 1, 1, 32'h0000_2000);
    chk("d2_iv",   32'(bus.inst_valid), 32'd1);
    chk("d2_pc",   bus.inst_pc, 32'h1004);
    chk("d2_req",  32'(bus.imem_req_valid), 32'd0);
    cyc(1, 0, 0, 1, 0, 0);
    chk("d3_addr", bus.imem_addr, 32'h2000);
    chk("d3_iv",   32'(bus.inst_valid), 32'd0);
    cyc(0, 1, mem_word(32'h2000), 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("d5_pc",   bus.inst_pc, 32'h2000);
    chk("d5_ins",  bus.inst,    mem_word(32'h2000));
    cyc(0, 0, 0, 1, 0, 0);
    chk("d6_iv",   32'(bus.inst_valid), 32'd0);

    // Request-ready toggling 1,0,1 with 3-cycle response latency.
    cyc(1, 0, 0, 1, 0, 0);
    chk("e0_addr", bus.imem_addr, 32'h2004);
    cyc(0, 0, 0, 1, 0, 0);
    chk("e1_addr", bus.imem_addr, 32'h2008);
    cyc(1, 0, 0, 1, 0, 0);
    chk("e2_addr", bus.imem_addr, 32'h2008);
    cyc(0, 1, mem_word(32'h2004), 1, 0, 0);
    chk("e3_iv",   32'(bus.inst_valid), 32'(BYP));
`ifdef IFETCH_BYPASS_EN
    chk("e3_pc",   bus.inst_pc, 32'h2004);
    chk("e3_ins",  bus.inst,    mem_word(32'h2004));
`endif
    cyc(0, 0, 0, 1, 0, 0);
    chk("e4_iv",   32'(bus.inst_valid), 32'(!BYP));
`ifndef IFETCH_BYPASS_EN
    chk("e4_pc",   bus.inst_pc, 32'h2004);
    chk("e4_ins",  bus.inst,    mem_word(32'h2004));
`endif
    cyc(0, 1, mem_word(32'h2008), 1, 0, 0);
    chk("e5_iv",   32'(bus.inst_valid), 32'(BYP));
`ifdef IFETCH_BYPASS_EN
    chk("e5_pc",   bus.inst_pc, 32'h2008);
`endif
    cyc(0, 0, 0, 1, 0, 0);
    chk("e6_iv",   32'(bus.inst_valid), 32'(!BYP));
`ifndef IFETCH_BYPASS_EN
    chk("e6_pc",   bus.inst_pc, 32'h2008);
`endif
    cyc(0, 0, 0, 1, 0, 0);
    chk("e7_iv",   32'(bus.inst_valid), 32'd0);

    // PC wrap at the top of the address space, then reset mid-stream.
    cyc(1, 0, 0, 1, 1, 32'hFFFF_FFFC);
    chk("f0_req",  32'(bus.imem_req_valid), 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("f1_addr", bus.imem_addr, 32'hFFFF_FFFC);
    cyc(1, 1, mem_word(32'hFFFF_FFFC), 0, 0, 0);
    chk("f2_addr", bus.imem_addr, 32'h0000_0000);
    chk("f2_req",  32'(bus.imem_req_valid), 32'd1);
    cyc(0, 1, mem_word(32'h0), 0, 0, 0);
    chk("f3_pc",   bus.inst_pc,  32'hFFFF_FFFC);
    chk("f3_pc4",  bus.inst_pc4, 32'h0000_0000);
    cyc(0, 0, 0, 1, 0, 0);
    chk("f4_ins",  bus.inst, mem_word(32'hFFFF_FFFC));
    cyc(0, 0, 0, 0, 0, 0);
    chk("f5_iv",   32'(bus.inst_valid), 32'd1);
    chk("f5_pc",   bus.inst_pc, 32'h0000_0000);
    pulse_reset("f_rst");
    cyc(1, 0, 0, 0, 0, 0);
    chk("g0_req",  32'(bus.imem_req_valid), 32'd1);
    chk("g0_addr", bus.imem_addr, 32'h40);
    chk("g0_iv",   32'(bus.inst_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
